// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, state type and sigma helpers
package sha256_pkg;

  localparam int SHA_WORD     = 32;
  localparam int SHA_W_LENGTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } w_exp_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  // Upper-case sigma variants used by the compression rounds.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

endpackage

// File: rtl/w_word_calc.sv
// rtl/w_word_calc.sv - combinational W[t] from the four schedule operands
module w_word_calc
  import sha256_pkg::*;
(
  input  logic [SHA_WORD-1:0] w_tm2_i,
  input  logic [SHA_WORD-1:0] w_tm7_i,
  input  logic [SHA_WORD-1:0] w_tm15_i,
  input  logic [SHA_WORD-1:0] w_tm16_i,
  output logic [SHA_WORD-1:0] w_t_o
);

  assign w_t_o = sigma1(w_tm2_i) + w_tm7_i + sigma0(w_tm15_i) + w_tm16_i;

endmodule

// File: rtl/w_expand_48.sv
// rtl/w_expand_48.sv - SHA-256 message schedule expansion, one word per clock
module w_expand_48
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = SHA_W_LENGTH,
  parameter int WORD     = SHA_WORD
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               start,
  input  logic [16*WORD-1:0]                 w16_vector,
  output logic [W_LENGTH*WORD-1:0]           w_vector,
  output logic [$clog2(W_LENGTH):0]          w_index,
  output logic                               busy,
  output logic                               w_expand_complete
);

  localparam int IDX_W = $clog2(W_LENGTH) + 1;

  w_exp_state_e               state_q, state_d;
  logic [W_LENGTH*WORD-1:0]   w_vec_q, w_vec_d;
  logic [WORD-1:0]            win_q [16];
  logic [WORD-1:0]            win_d [16];
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WORD-1:0]            w_new;

  // win_q[0] holds W[t-16], win_q[15] holds W[t-1].
  w_word_calc u_calc (
    .w_tm2_i  (win_q[14]),
    .w_tm7_i  (win_q[9]),
    .w_tm15_i (win_q[1]),
    .w_tm16_i (win_q[0]),
    .w_t_o    (w_new)
  );

  always_comb begin
    state_d = state_q;
    w_vec_d = w_vec_q;
    win_d   = win_q;
    idx_d   = idx_q;

    if (!enable) begin
      state_d = ST_IDLE;
      w_vec_d = '0;
      win_d   = '{default: '0};
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d                 = ST_EXPAND;
            w_vec_d                 = '0;
            w_vec_d[16*WORD-1:0]    = w16_vector;
            for (int i = 0; i < 16; i++) win_d[i] = w16_vector[i*WORD +: WORD];
            idx_d                   = IDX_W'(16);
          end
        end
        ST_EXPAND: begin
          w_vec_d[int'(idx_q)*WORD +: WORD] = w_new;
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_new;
          if (idx_q == IDX_W'(W_LENGTH - 1)) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          w_vec_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      w_vec_q <= '0;
      win_q   <= '{default: '0};
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      w_vec_q <= w_vec_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
    end
  end

  assign w_vector          = w_vec_q;
  assign w_index           = idx_q;
  assign busy              = (state_q == ST_EXPAND);
  assign w_expand_complete = (state_q == ST_DONE);

endmodule

// File: tb/tb_w_expand_48.sv
// tb/tb_w_expand_48.sv - self-checking bench for w_expand_48
module tb_w_expand_48;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic [511:0]  w16_vector;
  logic [2047:0] w_vector;
  logic [6:0]    w_index;
  logic          busy;
  logic          w_expand_complete;

  int tests = 0;
  int fails = 0;

  w_expand_48 dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .start             (start),
    .w16_vector        (w16_vector),
    .w_vector          (w_vector),
    .w_index           (w_index),
    .busy              (busy),
    .w_expand_complete (w_expand_complete)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0]  blk;
    logic [2047:0] exp;
  } vec_t;

  function automatic int unsigned ror(input int unsigned x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] model(input logic [511:0] blk);
    int unsigned w [64];
    logic [2047:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    int bad;
    bad = -1;
    for (int i = 63; i >= 0; i--)
      if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: word %0d got 0x%08h expected 0x%08h", name, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [511:0] blk);
    start      = 1'b1;
    w16_vector = blk;
    tick();
    start      = 1'b0;
  endtask

  // Counts edges from just after the capture edge until complete, bounded.
  task automatic wait_done(input int already, output int cyc);
    cyc = already;
    while (!w_expand_complete && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  logic [511:0] abc_blk;
  logic [511:0] other_blk;
  vec_t         tbl [6];
  int           cyc;

  initial begin
    abc_blk = '0;
    abc_blk[31:0]      = 32'h61626380;
    abc_blk[15*32 +: 32] = 32'h00000018;

    tbl[0].blk = abc_blk;
    tbl[1].blk = '0;
    for (int i = 2; i < 6; i++) tbl[i].blk = rand_blk();
    for (int i = 0; i < 6; i++) tbl[i].exp = model(tbl[i].blk);

    reset = 1'b0; enable = 1'b1; start = 1'b0; w16_vector = '0;
    #1;
    check_vec("reset_w_vector", w_vector, '0);
    check32("reset_w_index", 32'(w_index), 0);
    check32("reset_busy", 32'(busy), 0);
    check32("reset_complete", 32'(w_expand_complete), 0);
    #20;
    reset = 1'b1;
    tick();

    // Table-driven runs
    for (int v = 0; v < 6; v++) begin
      do_start(tbl[v].blk);
      wait_done(0, cyc);
      check32($sformatf("latency_v%0d", v), cyc, 48);
      check_vec($sformatf("vector_v%0d", v), w_vector, tbl[v].exp);
      check32($sformatf("idx_done_v%0d", v), 32'(w_index), 0);
      tick();
    end

    // Known "abc" words
    do_start(abc_blk);
    wait_done(0, cyc);
    check32("abc_w16", w_vector[16*32 +: 32], 32'h61626380);
    check32("abc_w17", w_vector[17*32 +: 32], 32'h000F0000);
    check32("abc_w18", w_vector[18*32 +: 32], 32'h7DA86405);
    check32("abc_w63", w_vector[63*32 +: 32], 32'h12B1EDEB);
    check32("abc_latency", cyc, 48);

    // Back-to-back restart from DONE with a different block
    other_blk = rand_blk();
    do_start(other_blk);
    check32("restart_complete_drop", 32'(w_expand_complete), 0);
    check32("restart_busy", 32'(busy), 1);
    check32("restart_idx", 32'(w_index), 16);
    wait_done(0, cyc);
    check32("restart_latency", cyc, 48);
    check_vec("restart_vector", w_vector, model(other_blk));

    // All-zero block: busy and index stepping
    do_start('0);
    for (int k = 0; k < 48; k++) begin
      check32($sformatf("zero_busy_%0d", k), 32'(busy), 1);
      check32($sformatf("zero_idx_%0d", k), 32'(w_index), 16 + k);
      tick();
    end
    check32("zero_complete", 32'(w_expand_complete), 1);
    check32("zero_busy_end", 32'(busy), 0);
    check32("zero_idx_end", 32'(w_index), 0);
    check_vec("zero_vector", w_vector, '0);

    // Reset asserted mid-expansion
    do_start(abc_blk);
    for (int k = 0; k < 20; k++) tick();
    reset = 1'b0;
    #2;
    check_vec("rst_mid_vector", w_vector, '0);
    check32("rst_mid_idx", 32'(w_index), 0);
    check32("rst_mid_busy", 32'(busy), 0);
    check32("rst_mid_complete", 32'(w_expand_complete), 0);
    #10;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check32("rst_after_busy", 32'(busy), 0);
    check32("rst_after_idx", 32'(w_index), 0);
    check32("rst_after_complete", 32'(w_expand_complete), 0);

    // Enable dropped mid-expansion, then a fresh run
    do_start(abc_blk);
    for (int k = 0; k < 30; k++) tick();
    enable = 1'b0;
    tick();
    check_vec("en_drop_vector", w_vector, '0);
    check32("en_drop_busy", 32'(busy), 0);
    check32("en_drop_idx", 32'(w_index), 0);
    enable = 1'b1;
    tick();
    do_start(abc_blk);
    wait_done(0, cyc);
    check32("en_rerun_w63", w_vector[63*32 +: 32], 32'h12B1EDEB);

    // start pulsed mid-expansion is ignored
    other_blk = rand_blk();
    do_start(abc_blk);
    for (int k = 0; k < 9; k++) tick();
    start = 1'b1; w16_vector = other_blk;
    tick();
    start = 1'b0;
    wait_done(10, cyc);
    check32("ign_start_latency", cyc, 48);
    check_vec("ign_start_vector", w_vector, tbl[0].exp);

    // Simultaneous start and enable drop from DONE
    start = 1'b1; enable = 1'b0; w16_vector = other_blk;
    tick();
    start = 1'b0; enable = 1'b1;
    check32("sim_drop_busy", 32'(busy), 0);
    check32("sim_drop_complete", 32'(w_expand_complete), 0);
    check32("sim_drop_idx", 32'(w_index), 0);
    check_vec("sim_drop_vector", w_vector, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
